prio_encoder_pipe: RTL and testbench

- Parametrised N-input priority encoder with a registered, handshaked output stage.
- Successor to the fixed 4-to-2 encoder: generic width, "any request" flag, popcount output, and a selectable round-robin mode with a rotating priority pointer.
- Sits between request sources, such as interrupt lines or channel requests, and a downstream consumer that can apply backpressure.

---
 rtl/prio_encoder_pipe_if.sv | 31 +++
 rtl/prio_encoder_pipe.sv | 106 ++++++++++
 tb/tb_prio_encoder_pipe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : prio_encoder_pipe_if
// Purpose  : Request/result handshake bundle for prio_encoder_pipe.
//            master = request source / result consumer, slave = encoder.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface prio_encoder_pipe_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) ();
  logic [N-1:0] req;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic         out_any;
  logic [W:0]   out_count;

  modport master (
    output req, in_valid, out_ready,
    input  in_ready, out_valid, out_code, out_any, out_count
  );

  modport slave (
    input  req, in_valid, out_ready,
    output in_ready, out_valid, out_code, out_any, out_count
  );
endinterface
`default_nettype wire

// File: rtl/prio_encoder_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : prio_encoder_pipe
// Purpose  : N-input priority encoder (fixed highest-index or round-robin)
//            with a single-entry registered, handshaked result stage.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module prio_encoder_pipe #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  wire                clk,
  input  wire                rst_n,
  prio_encoder_pipe_if.slave io
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] c_last = W'(N - 1);
  localparam logic [W:0]   c_n    = (W + 1)'(N);

  logic         r_valid;
  logic [W-1:0] r_code;
  logic         r_any;
  logic [W:0]   r_count;

  logic         w_in_ready;
  logic         w_accept;
  logic         w_any;
  logic [W:0]   w_count;
  logic [W-1:0] w_code;

  // A new request may enter whenever the output slot is empty or being drained
  assign w_in_ready = !r_valid || io.out_ready;
  assign w_accept   = io.in_valid && w_in_ready;
  assign w_any      = |io.req;

  assign io.in_ready  = w_in_ready;
  assign io.out_valid = r_valid;
  assign io.out_code  = r_code;
  assign io.out_any   = r_any;
  assign io.out_count = r_count;

  // Population count of the request vector
  always_comb begin
    w_count = '0;
    for (int i = 0; i < N; i++) begin
      w_count = w_count + {{W{1'b0}}, io.req[i]};
    end
  end

  generate
    if (MODE == 0) begin : g_fixed
      // Highest set index wins: later loop iterations override earlier ones
      always_comb begin
        w_code = '0;
        for (int i = 0; i < N; i++) begin
          if (io.req[i]) w_code = W'(i);
        end
      end
    end else begin : g_rr
      logic [W-1:0] r_ptr;
      logic [W:0]   w_sum;
      logic [W-1:0] w_idx;

      // Scan from ptr upward with wrap at N; descending offsets so the
      // smallest offset from ptr is the last (winning) assignment
      always_comb begin
        w_code = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
          w_sum = {1'b0, r_ptr} + (W + 1)'(k);
          if (w_sum >= c_n) w_sum = w_sum - c_n;
          w_idx = w_sum[W-1:0];
          if (io.req[w_idx]) w_code = w_idx;
        end
      end

      // Pointer moves just past the grant, only on a non-empty accept
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= '0;
        end else if (w_accept && w_any) begin
          r_ptr <= (w_code == c_last) ? '0 : w_code + 1'b1;
        end
      end
    end
  endgenerate

  // Single-entry result register: load on accept, empty on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_any   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_code  <= w_code;
      r_any   <= w_any;
      r_count <= w_count;
    end else if (io.out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_prio_encoder_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_prio_encoder_pipe
// Purpose  : Directed self-checking bench for prio_encoder_pipe in
//            MODE=0/N=8, MODE=1/N=4 and MODE=1/N=5 configurations.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_prio_encoder_pipe;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  prio_encoder_pipe_if #(.N(8)) if8 ();
  prio_encoder_pipe_if #(.N(4)) if4 ();
  prio_encoder_pipe_if #(.N(5)) if5 ();

  prio_encoder_pipe #(.N(8), .MODE(0)) u_dut8 (.clk(clk), .rst_n(rst_n), .io(if8));
  prio_encoder_pipe #(.N(4), .MODE(1)) u_dut4 (.clk(clk), .rst_n(rst_n), .io(if4));
  prio_encoder_pipe #(.N(5), .MODE(1)) u_dut5 (.clk(clk), .rst_n(rst_n), .io(if5));

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp[5];
    int alt_exp[3];
    rr_exp  = '{0, 1, 2, 3, 0};
    alt_exp = '{1, 3, 1};
    n_total = 0;
    n_pass  = 0;

    if8.req = '0; if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    if4.req = '0; if4.in_valid = 1'b0; if4.out_ready = 1'b1;
    if5.req = '0; if5.in_valid = 1'b0; if5.out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    chk("rst_valid8", if8.out_valid, 1'b0);
    chk("rst_code8",  if8.out_code,  3'd0);
    chk("rst_count8", if8.out_count, 4'd0);
    chk("rst_ready8", if8.in_ready,  1'b1);

    // Fixed priority, N=8
    if8.req = 8'b0110_0000; if8.in_valid = 1'b1;
    step();
    chk("fx_valid", if8.out_valid, 1'b1);
    chk("fx_code",  if8.out_code,  3'd6);
    chk("fx_any",   if8.out_any,   1'b1);
    chk("fx_count", if8.out_count, 4'd2);

    if8.req = 8'h00;
    step();
    chk("fx0_valid", if8.out_valid, 1'b1);
    chk("fx0_code",  if8.out_code,  3'd0);
    chk("fx0_any",   if8.out_any,   1'b0);
    chk("fx0_count", if8.out_count, 4'd0);

    if8.req = 8'hFF;
    step();
    chk("fxff_code",  if8.out_code,  3'd7);
    chk("fxff_count", if8.out_count, 4'd8);

    if8.req = 8'b0000_0001;
    step();
    chk("fx1_code",  if8.out_code,  3'd0);
    chk("fx1_any",   if8.out_any,   1'b1);

    if8.in_valid = 1'b0;
    step();
    chk("fx_drain", if8.out_valid, 1'b0);

    // Round-robin, N=5 wrap
    if5.req = 5'b10000; if5.in_valid = 1'b1;
    step();
    chk("n5_code4", if5.out_code, 3'd4);
    if5.req = 5'b10001;
    step();
    chk("n5_wrap",  if5.out_code, 3'd0);
    chk("n5_count", if5.out_count, 4'd2);
    step();
    chk("n5_next",  if5.out_code, 3'd4);
    if5.in_valid = 1'b0;

    // Round-robin, N=4, all requesting
    if4.req = 4'b1111; if4.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr_code%0d", i), if4.out_code, rr_exp[i]);
      chk($sformatf("rr_valid%0d", i), if4.out_valid, 1'b1);
    end
    if4.req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("alt_code%0d", i), if4.out_code, alt_exp[i]);
    end

    // ptr=2 here: two more grants bring it back to 0, then drain
    if4.req = 4'b1111;
    step();
    chk("rr_p2", if4.out_code, 2'd2);
    step();
    chk("rr_p3", if4.out_code, 2'd3);
    if4.in_valid = 1'b0;
    step();
    chk("rr_drain", if4.out_valid, 1'b0);

    // Backpressure
    if4.in_valid = 1'b1;
    step();
    chk("bp_first", if4.out_code, 2'd0);
    if4.out_ready = 1'b0;
    #1;
    chk("bp_ready0", if4.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_code%0d", i), if4.out_code, 2'd0);
      chk($sformatf("bp_hold_valid%0d", i), if4.out_valid, 1'b1);
      chk($sformatf("bp_hold_ready%0d", i), if4.in_ready, 1'b0);
    end
    if4.out_ready = 1'b1;
    #1;
    chk("bp_ready1", if4.in_ready, 1'b1);
    step();
    chk("bp_release", if4.out_code, 2'd1);
    chk("bp_valid",   if4.out_valid, 1'b1);

    // Async reset between edges with out_valid=1, ptr=2
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", if4.out_valid, 1'b0);
    chk("ar_code",  if4.out_code,  2'd0);
    chk("ar_any",   if4.out_any,   1'b0);
    chk("ar_count", if4.out_count, 3'd0);
    chk("ar_ready", if4.in_ready,  1'b1);
    step();
    #2;
    rst_n = 1'b1;
    if4.out_ready = 1'b1;
    if4.req = 4'b1111;
    if4.in_valid = 1'b1;
    step();
    chk("ar_after", if4.out_code, 2'd0);
    chk("ar_after_valid", if4.out_valid, 1'b1);
    if4.in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
